// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, serves mthi/mtlo,
// and holds Busy for a fixed number of cycles per operation.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MultDivStart,
  input  logic [1:0]  MultDivOp,
  input  logic        HiLoWe,
  input  logic        HiLo,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [31:0]   p_hi, p_lo;
  logic          p_valid;
  logic          done;

  // Result is computed entirely at the start edge; RUN only models latency.
  logic        sgn, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_valid;

  assign sgn   = MultDivOp[0];
  assign a_ext = {{32{sgn & A[31]}}, A};
  assign b_ext = {{32{sgn & B[31]}}, B};
  assign prod  = a_ext * b_ext;

  assign a_neg = sgn & A[31];
  assign b_neg = sgn & B[31];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  assign res_hi    = MultDivOp[1] ? rem  : prod[63:32];
  assign res_lo    = MultDivOp[1] ? quot : prod[31:0];
  assign res_valid = !(MultDivOp[1] && (B == 32'd0));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (MultDivStart) state_nx = RUN;
      RUN:     if (done)         state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN);
    done = (state == RUN) && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      p_valid <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (state == IDLE) begin
      if (MultDivStart) begin
        p_hi    <= res_hi;
        p_lo    <= res_lo;
        p_valid <= res_valid;
        cnt     <= MultDivOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (HiLoWe) begin
        if (HiLo) HI <= A;
        else      LO <= A;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (done && p_valid) begin
        HI <= p_hi;
        LO <= p_lo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/busy-length,
// a negedge monitor pops and compares on each Busy falling edge.
module tb_muldiv_unit;
  localparam int MC = 5, DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic        MultDivStart;
  logic [1:0]  MultDivOp;
  logic        HiLoWe, HiLo;
  logic [31:0] HI, LO;
  logic        Busy;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MultDivStart(MultDivStart),
    .MultDivOp(MultDivOp), .HiLoWe(HiLoWe), .HiLo(HiLo),
    .HI(HI), .LO(LO), .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_bad = 0;
  int          run = 0;
  logic [31:0] mhi = '0, mlo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: count busy cycles, compare on completion
  always @(negedge clk) begin
    if (Busy === 1'b1) run++;
    else if (run > 0) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got completion after %0d cycles expected none", run);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_hi"}, 64'(HI), 64'(mon_e.hi));
        chk({mon_e.name, "_lo"}, 64'(LO), 64'(mon_e.lo));
        chk({mon_e.name, "_busy_len"}, 64'(run), 64'(mon_e.cyc));
      end
      run = 0;
    end
  end

  // Reference model from plain arithmetic
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      q, r;
    logic [63:0] p;
    if (!op[1]) begin
      if (op[0]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else       p = {32'd0, a} * {32'd0, b};
      mhi = p[63:32];
      mlo = p[31:0];
    end else if (b != 0) begin
      if (op[0]) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        mlo = q[31:0];
        mhi = r[31:0];
      end else begin
        mlo = a / b;
        mhi = a % b;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (Busy !== 1'b0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got Busy=%b expected 0 within 40 cycles", nm, Busy);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
    exp_t e;
    model_op(op, a, b);
    e.hi = mhi; e.lo = mlo; e.cyc = op[1] ? DC : MC; e.name = nm;
    sb.push_back(e);
    MultDivStart = 1'b1; MultDivOp = op; A = a; B = b;
    @(posedge clk); #1;
    MultDivStart = 1'b0;
    A = $urandom; B = $urandom;
    wait_idle(nm);
  endtask

  task automatic mt(input logic h, input logic [31:0] v, input string nm);
    HiLoWe = 1'b1; HiLo = h; A = v;
    @(posedge clk); #1;
    HiLoWe = 1'b0; A = $urandom;
    if (h) mhi = v; else mlo = v;
    chk({nm, "_hi"}, 64'(HI), 64'(mhi));
    chk({nm, "_lo"}, 64'(LO), 64'(mlo));
    chk({nm, "_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    exp_t        e;
    logic [1:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; A = '0; B = '0; MultDivStart = 1'b0; MultDivOp = '0;
    HiLoWe = 1'b0; HiLo = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hi", 64'(HI), 64'd0);
    chk("idle_lo", 64'(LO), 64'd0);
    chk("idle_busy", 64'(Busy), 64'd0);

    run_op(2'b01, 32'hFFFFFFFE, 32'h3, "mult");
    chk("mult_hi_const", 64'(mhi), 64'hFFFFFFFF);
    run_op(2'b00, 32'hFFFFFFFE, 32'h3, "multu");
    run_op(2'b11, 32'hFFFFFFF9, 32'h2, "div");
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, "divu");
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(2'b11, 32'h00000007, 32'hFFFFFFFE, "div_negb");

    mt(1'b1, 32'h11111111, "mthi");
    mt(1'b0, 32'h22222222, "mtlo");
    run_op(2'b10, 32'h12345678, 32'h0, "divu_zero");
    run_op(2'b11, 32'h87654321, 32'h0, "div_zero");

    // Writes and a second start during RUN must be ignored
    model_op(2'b01, 32'd7, 32'd9);
    e.hi = mhi; e.lo = mlo; e.cyc = MC; e.name = "ign";
    sb.push_back(e);
    MultDivStart = 1'b1; MultDivOp = 2'b01; A = 32'd7; B = 32'd9;
    @(posedge clk); #1;
    MultDivStart = 1'b0;
    @(posedge clk); #1;
    HiLoWe = 1'b1; HiLo = 1'b0; A = 32'h55; B = 32'd3; MultDivStart = 1'b1; MultDivOp = 2'b00;
    @(posedge clk); #1;
    HiLoWe = 1'b0; MultDivStart = 1'b0;
    chk("ign_mtlo", 64'(LO), 64'h22222222);
    wait_idle("ign");

    // Reset in the 4th busy cycle aborts the divide
    e.hi = '0; e.lo = '0; e.cyc = 4; e.name = "rst_mid";
    sb.push_back(e);
    MultDivStart = 1'b1; MultDivOp = 2'b11; A = 32'd1000; B = 32'd7;
    @(posedge clk); #1;
    MultDivStart = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mhi = '0; mlo = '0;
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("rst_late_hi", 64'(HI), 64'd0);
    chk("rst_late_lo", 64'(LO), 64'd0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom_range(1, 100);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h80000000;
      if ($urandom_range(0, 5) == 0) mt(1'($urandom_range(0, 1)), $urandom, "rnd_mt");
      run_op(op, a, b, "rnd");
    end

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL pending: got %0d outstanding results expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multiply/divide unit of the P5 pipelined CPU, in the EX stage directly downstream of the instruction decoder. It consumes the decoder's MultDivStart, MultDivOp, HiLoWe and HiLo controls plus the two forwarded EX operands. It performs multi-cycle mult/multu/div/divu into the HI/LO registers and services mthi/mtlo writes. It exports HI, LO and Busy so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo while an operation is in flight.

## Interface
- MULT_CYCLES, 5, Busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, Busy cycles for div/divu (≥1)

- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- A  in  32  rs operand (after forwarding)
- B  in  32  rt operand (after forwarding)
- MultDivStart  in  1  start pulse for mult/multu/div/divu
- MultDivOp  in  2  bit0 = signed, bit1 = divide (00 multu, 01 mult, 10 divu, 11 div)
- HiLoWe  in  1  mthi/mtlo write enable
- HiLo  in  1  1 = write HI (mthi), 0 = write LO (mtlo)
- HI  out  32  HI register
- LO  out  32  LO register
- Busy  out  1  operation in flight (registered)

## Operation
- State: IDLE, RUN. Internal: down-counter cnt (4 bits minimum, sized for max parameter), pending result regs pHI/pLO, flag pValid.
- IDLE + MultDivStart:
  - Compute result from A/B/MultDivOp and latch into pHI/pLO.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- Multiply: {pHI,pLO} = 64-bit product. Operands are sign-extended when MultDivOp[0]=1 and zero-extended otherwise.
- Divide: pLO = quotient truncated toward zero; pHI = remainder, with the sign of the dividend (A).
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, div or divu): runs the full DIV_CYCLES with Busy asserted. HI/LO are left unchanged at completion (pValid=0).
- RUN: cnt decrements every cycle. When cnt==1, at that edge HI/LO ← pHI/pLO (if pValid) and the state returns to IDLE.
- IDLE + HiLoWe (no Start): HI ← A if HiLo=1, else LO ← A.
- Simultaneous Start and HiLoWe in IDLE: Start wins, HiLoWe is ignored (the decoder never issues both).
- MultDivStart or HiLoWe while in RUN: ignored, with no effect on the current operation. Preventing this is the hazard unit's job.
- reset: HI=0, LO=0, Busy=0, state=IDLE, cnt=0, pValid=0.
  - Reset mid-operation aborts the operation; HI/LO are not written.
- HI and LO are driven directly from registers; there is no combinational path from inputs to outputs.

## Timing
- Start sampled at edge E0 (cycle T0). Busy=1 during cycles T0+1 … T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new value at the edge ending cycle T0+N. They are valid from T0+N+1, the same cycle Busy returns to 0.
- Busy is 0 in cycle T0 itself. The hazard unit stalls on (Busy | MultDivStart) for dependent instructions.
- A back-to-back Start is accepted in cycle T0+N+1, the first cycle Busy=0.
- mthi/mtlo: 1-cycle latency. A write at edge E is visible on HI/LO in the cycle after E. Busy is unaffected.
- A/B are sampled only at the Start edge. Later changes to A/B do not affect the result.

## Test plan
- Reset then idle: assert reset 2 cycles -> HI=0, LO=0, Busy=0. With no stimulus, the outputs hold.
- mult, A=0xFFFFFFFE (-2), B=0x00000003, Op=01 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu (Op=00) -> HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (-7), B=2, Op=11 -> Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands -> LO=0x7FFFFFFC, HI=1.
- Divide by zero: preload HI=0x11111111 and LO=0x22222222 via mthi/mtlo, then divu with B=0 -> Busy high for 10 cycles, then HI/LO unchanged.
- Ignored writes: Start a mult, then pulse mtlo with A=0x55 and a second Start while Busy -> only the first mult result lands. A=0x55 is not written, and Busy drops after 5 cycles total.
- Reset mid-op: Start div, assert reset in busy cycle 4 -> next cycle Busy=0, HI=0, LO=0. No late write occurs afterward.
